uart_tx_hakem: RTL and testbench

Round-robin arbiter that shares the single UART transmit path among `N` byte requesters. Each requester offers bytes on its own valid/ready channel and may lock the transmitter for a multi-byte frame. The winning byte is packed into a UART send command word `{byte, 21'b0, 3'b001}` and presented on the UART wrapper's command handshake (`komut` / `komut_gecerli` / `komut_hazir`). It sits between the on-chip masters (CPU, debug, test logic) and the UART wrapper.

---
 rtl/uart_gfa_pkg.sv | 23 ++
 rtl/uart_tx_hakem_rr_secici.sv | 30 +++
 rtl/uart_tx_hakem.sv | 133 +++++++++++++
 tb/tb_uart_tx_hakem.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_gfa_pkg.sv
// Shared definitions for the UART transmit arbiter: command opcode,
// FSM state encoding, command word field positions, counter sizing helper.
package uart_gfa_pkg;

  localparam logic [2:0] KOMUT_GONDER = 3'b001;

  localparam logic [1:0] BOSTA   = 2'd0;
  localparam logic [1:0] GONDER  = 2'd1;
  localparam logic [1:0] KILITLI = 2'd2;

  localparam int BAYT_MSB  = 31;
  localparam int BAYT_LSB  = 24;
  localparam int OPKOD_MSB = 2;
  localparam int OPKOD_LSB = 0;

  // Idle counter width; a disabled timeout (0) still gets a 1-bit counter
  // so the declaration never collapses to zero width.
  function automatic int sayac_genisligi(input int zaman_asimi);
    if (zaman_asimi < 1) return 1;
    return $clog2(zaman_asimi + 1);
  endfunction

endpackage

// File: rtl/uart_tx_hakem_rr_secici.sv
// Combinational round-robin selector: first asserted request found when
// scanning upward from the pointer, wrapping modulo N.
module rr_secici #(
  parameter int N = 4
) (
  input  logic [N-1:0]         istek,
  input  logic [$clog2(N)-1:0] oncelik,
  output logic                 bulundu,
  output logic [$clog2(N)-1:0] kazanan
);

  localparam int W = $clog2(N);

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    bulundu = 1'b0;
    kazanan = '0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(oncelik) + k;
      if (j >= N) j = j - N;
      if (!bulundu && istek[j]) begin
        bulundu = 1'b1;
        kazanan = W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_hakem.sv
// Round-robin arbiter sharing one UART command channel among N byte
// requesters, with optional multi-byte frame locking and idle timeout.
module uart_tx_hakem
  import uart_gfa_pkg::*;
#(
  parameter int N           = 4,
  parameter int ZAMAN_ASIMI = 1024
) (
  input  logic                 clk_g,
  input  logic                 rst_g,
  input  logic [N-1:0]         istek_gecerli,
  input  logic [8*N-1:0]       istek_veri,
  input  logic [N-1:0]         istek_son,
  output logic [N-1:0]         istek_hazir,
  output logic [31:0]          komut,
  output logic                 komut_gecerli,
  input  logic                 komut_hazir,
  output logic [$clog2(N)-1:0] sahip,
  output logic                 mesgul
);

  localparam int W  = $clog2(N);
  localparam int SW = sayac_genisligi(ZAMAN_ASIMI);

  logic [1:0]    durum_q,   durum_d;
  logic [W-1:0]  oncelik_q, oncelik_d;
  logic [W-1:0]  sahip_q,   sahip_d;
  logic [7:0]    bayt_q,    bayt_d;
  logic          son_q,     son_d;
  logic [SW-1:0] sayac_q,   sayac_d;

  logic          bulundu;
  logic [W-1:0]  kazanan;
  logic [W-1:0]  sonraki_oncelik;
  logic [SW:0]   sayac_art;

  rr_secici #(.N(N)) u_secici (
    .istek   (istek_gecerli),
    .oncelik (oncelik_q),
    .bulundu (bulundu),
    .kazanan (kazanan)
  );

  // Pointer successor of the owner, wrapping for any N.
  assign sonraki_oncelik = (sahip_q == W'(N - 1)) ? '0 : sahip_q + 1'b1;
  assign sayac_art       = {1'b0, sayac_q} + 1'b1;

  // Next-state, byte capture and accept strobes for the arbitration FSM.
  always_comb begin
    durum_d     = durum_q;
    oncelik_d   = oncelik_q;
    sahip_d     = sahip_q;
    bayt_d      = bayt_q;
    son_d       = son_q;
    sayac_d     = sayac_q;
    istek_hazir = '0;
    case (durum_q)
      BOSTA: begin
        if (bulundu) begin
          istek_hazir[kazanan] = 1'b1;
          bayt_d  = istek_veri[{kazanan, 3'b000} +: 8];
          son_d   = istek_son[kazanan];
          sahip_d = kazanan;
          durum_d = GONDER;
        end
      end
      GONDER: begin
        if (komut_hazir) begin
          if (son_q) begin
            oncelik_d = sonraki_oncelik;
            durum_d   = BOSTA;
          end else begin
            sayac_d = '0;
            durum_d = KILITLI;
          end
        end
      end
      KILITLI: begin
        istek_hazir[sahip_q] = 1'b1;
        if (istek_gecerli[sahip_q]) begin
          bayt_d  = istek_veri[{sahip_q, 3'b000} +: 8];
          son_d   = istek_son[sahip_q];
          durum_d = GONDER;
        end else begin
          if (sayac_q != {SW{1'b1}}) sayac_d = sayac_art[SW-1:0];
          if (ZAMAN_ASIMI != 0 && int'(sayac_art) >= ZAMAN_ASIMI) begin
            oncelik_d = sonraki_oncelik;
            durum_d   = BOSTA;
          end
        end
      end
      default: durum_d = BOSTA;
    endcase
    // No byte may be accepted while reset is asserted.
    if (!rst_g) istek_hazir = '0;
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk_g) begin
    if (!rst_g) begin
      durum_q   <= BOSTA;
      oncelik_q <= '0;
      sahip_q   <= '0;
      son_q     <= 1'b0;
      sayac_q   <= '0;
    end else begin
      durum_q   <= durum_d;
      oncelik_q <= oncelik_d;
      sahip_q   <= sahip_d;
      son_q     <= son_d;
      sayac_q   <= sayac_d;
    end
  end

  // Latched byte; only visible through komut while a command is valid.
  always_ff @(posedge clk_g) begin
    bayt_q <= bayt_d;
  end

  // Command word is forced to zero whenever no command is offered.
  always_comb begin
    komut = '0;
    if (komut_gecerli) begin
      komut[BAYT_MSB:BAYT_LSB]   = bayt_q;
      komut[OPKOD_MSB:OPKOD_LSB] = KOMUT_GONDER;
    end
  end

  assign komut_gecerli = (durum_q == GONDER);
  assign mesgul        = (durum_q != BOSTA);
  assign sahip         = sahip_q;

endmodule

// File: tb/tb_uart_tx_hakem.sv
// Bench for uart_tx_hakem: directed scenarios plus random traffic checked
// against a transaction-level arbitration model.
module tb_uart_tx_hakem;

  localparam int N  = 4;
  localparam int ZA = 8;

  logic           clk_g = 1'b0;
  logic           rst_g;
  logic [N-1:0]   istek_gecerli;
  logic [8*N-1:0] istek_veri;
  logic [N-1:0]   istek_son;
  logic [N-1:0]   istek_hazir;
  logic [31:0]    komut;
  logic           komut_gecerli;
  logic           komut_hazir;
  logic [1:0]     sahip;
  logic           mesgul;

  always #5 clk_g = ~clk_g;

  uart_tx_hakem #(.N(N), .ZAMAN_ASIMI(ZA)) dut (
    .clk_g         (clk_g),
    .rst_g         (rst_g),
    .istek_gecerli (istek_gecerli),
    .istek_veri    (istek_veri),
    .istek_son     (istek_son),
    .istek_hazir   (istek_hazir),
    .komut         (komut),
    .komut_gecerli (komut_gecerli),
    .komut_hazir   (komut_hazir),
    .sahip         (sahip),
    .mesgul        (mesgul)
  );

  int toplam = 0;
  int bad    = 0;
  int dongu  = 0;

  // Per-requester byte sources: {son, byte}
  logic [8:0]  kuyruk [N][$];
  logic [31:0] gozlem_q [$];
  int          gozlem_t [$];
  logic [N-1:0] son_hazir;

  // Reference model state
  bit       m_pend  = 0;
  bit       m_lock  = 0;
  bit       m_last  = 0;
  logic [7:0] m_byte = '0;
  int       m_owner = 0;
  int       m_ptr   = 0;
  int       m_idle  = 0;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    toplam++;
    if (gozlenen !== beklenen) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", etiket, gozlenen, beklenen, dongu);
    end
  endtask

  function automatic logic [31:0] komut_yap(input logic [7:0] b);
    return {b, 21'b0, 3'b001};
  endfunction

  function automatic logic [31:0] gozlem_al(input int i);
    if (i < gozlem_q.size()) return gozlem_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic bit kuyruklar_bos();
    for (int i = 0; i < N; i++) if (kuyruk[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic surucu_guncelle();
    for (int i = 0; i < N; i++) begin
      if (kuyruk[i].size() != 0) begin
        istek_gecerli[i]      = 1'b1;
        istek_veri[8*i +: 8]  = kuyruk[i][0][7:0];
        istek_son[i]          = kuyruk[i][0][8];
      end else begin
        istek_gecerli[i]      = 1'b0;
        istek_veri[8*i +: 8]  = 8'h00;
        istek_son[i]          = 1'b0;
      end
    end
  endtask

  // One clock: drive sources, compare at negedge, advance model and sources.
  task automatic adim(input bit denetle);
    logic [N-1:0] b_hazir;
    logic [31:0]  b_komut;
    logic         b_gec;
    int           kazanan;
    int           j;
    surucu_guncelle();
    @(negedge clk_g);
    dongu++;
    b_gec   = m_pend;
    b_komut = m_pend ? komut_yap(m_byte) : 32'h0;
    b_hazir = '0;
    kazanan = -1;
    if (rst_g && !m_pend) begin
      if (m_lock) b_hazir[m_owner] = 1'b1;
      else begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (kazanan < 0 && istek_gecerli[j]) kazanan = j;
        end
        if (kazanan >= 0) b_hazir[kazanan] = 1'b1;
      end
    end
    if (denetle) begin
      kontrol("istek_hazir",   32'(istek_hazir),   32'(b_hazir));
      kontrol("komut_gecerli", 32'(komut_gecerli), 32'(b_gec));
      kontrol("komut",         komut,              b_komut);
      kontrol("sahip",         32'(sahip),         32'(m_owner));
      kontrol("mesgul",        32'(mesgul),        32'(m_pend || m_lock));
    end
    son_hazir = istek_hazir;
    if (rst_g && komut_gecerli && komut_hazir) begin
      gozlem_q.push_back(komut);
      gozlem_t.push_back(dongu);
    end
    if (!rst_g) begin
      m_pend = 0; m_lock = 0; m_last = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
    end else if (m_pend) begin
      if (komut_hazir) begin
        m_pend = 0;
        if (m_last) begin
          m_lock = 0;
          m_ptr  = (m_owner + 1) % N;
        end else begin
          m_lock = 1;
          m_idle = 0;
        end
      end
    end else if (m_lock) begin
      if (istek_gecerli[m_owner]) begin
        m_pend = 1;
        m_byte = istek_veri[8*m_owner +: 8];
        m_last = istek_son[m_owner];
      end else begin
        m_idle++;
        if (m_idle >= ZA) begin
          m_lock = 0;
          m_ptr  = (m_owner + 1) % N;
        end
      end
    end else if (kazanan >= 0) begin
      m_pend  = 1;
      m_owner = kazanan;
      m_byte  = istek_veri[8*kazanan +: 8];
      m_last  = istek_son[kazanan];
    end
    for (int i = 0; i < N; i++)
      if (rst_g && istek_gecerli[i] && istek_hazir[i] && kuyruk[i].size() != 0)
        void'(kuyruk[i].pop_front());
    @(posedge clk_g);
    #1;
  endtask

  task automatic bosalt();
    for (int k = 0; k < 300; k++) begin
      if (kuyruklar_bos() && !mesgul && !m_pend && !m_lock) break;
      adim(1);
    end
    kontrol("bosalt_mesgul", 32'(mesgul), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_g         = 1'b0;
    komut_hazir   = 1'b1;
    istek_gecerli = '0;
    istek_veri    = '0;
    istek_son     = '0;
    son_hazir     = '0;

    // Reset with every requester active
    kuyruk[0].push_back(9'h110);
    kuyruk[0].push_back(9'h110);
    kuyruk[1].push_back(9'h121);
    kuyruk[2].push_back(9'h132);
    kuyruk[3].push_back(9'h143);
    repeat (3) adim(1);
    kontrol("rst_hazir",   32'(istek_hazir),   32'h0);
    kontrol("rst_gecerli", 32'(komut_gecerli), 32'h0);
    kontrol("rst_komut",   komut,              32'h0);
    kontrol("rst_sahip",   32'(sahip),         32'h0);
    kontrol("rst_mesgul",  32'(mesgul),        32'h0);

    // Single-byte round robin
    rst_g = 1'b1;
    n0 = gozlem_q.size();
    adim(1);
    kontrol("ilk_kazanan", 32'(son_hazir), 32'h1);
    repeat (9) adim(1);
    kontrol("rr_0", gozlem_al(n0),     32'h1000_0001);
    kontrol("rr_1", gozlem_al(n0 + 1), 32'h2100_0001);
    kontrol("rr_2", gozlem_al(n0 + 2), 32'h3200_0001);
    kontrol("rr_3", gozlem_al(n0 + 3), 32'h4300_0001);
    kontrol("rr_4", gozlem_al(n0 + 4), 32'h1000_0001);
    bosalt();

    // Move the pointer to 2, then a locked frame from requester 2
    kuyruk[1].push_back(9'h15F);
    bosalt();
    n0 = gozlem_q.size();
    kuyruk[2].push_back(9'h0A1);
    kuyruk[2].push_back(9'h0A2);
    kuyruk[2].push_back(9'h1A3);
    kuyruk[0].push_back(9'h101);
    kuyruk[1].push_back(9'h102);
    bosalt();
    kontrol("cerceve_0", gozlem_al(n0),     32'hA100_0001);
    kontrol("cerceve_1", gozlem_al(n0 + 1), 32'hA200_0001);
    kontrol("cerceve_2", gozlem_al(n0 + 2), 32'hA300_0001);
    kontrol("cerceve_3", gozlem_al(n0 + 3), 32'h0100_0001);
    kontrol("cerceve_4", gozlem_al(n0 + 4), 32'h0200_0001);

    // Back-pressure
    kuyruk[3].push_back(9'h155);
    komut_hazir = 1'b0;
    adim(1);
    n0 = gozlem_q.size();
    for (int k = 0; k < 20; k++) begin
      adim(1);
      kontrol("bp_komut",   komut,              32'h5500_0001);
      kontrol("bp_gecerli", 32'(komut_gecerli), 32'h1);
    end
    komut_hazir = 1'b1;
    adim(1);
    adim(1);
    kontrol("bp_tek", 32'(gozlem_q.size() - n0), 32'h1);
    kontrol("bp_kelime", gozlem_al(n0), 32'h5500_0001);
    bosalt();

    // Lock timeout
    n0 = gozlem_q.size();
    kuyruk[1].push_back(9'h077);
    adim(1);
    kuyruk[2].push_back(9'h188);
    repeat (14) adim(1);
    kontrol("za_0", gozlem_al(n0),     32'h7700_0001);
    kontrol("za_1", gozlem_al(n0 + 1), 32'h8800_0001);
    if (gozlem_t.size() >= n0 + 2)
      kontrol("za_sure", 32'(gozlem_t[n0 + 1] - gozlem_t[n0]), 32'd10);
    else
      kontrol("za_sure", 32'(gozlem_t.size() - n0), 32'd2);
    bosalt();

    // Reset in the middle of a lock
    kuyruk[0].push_back(9'h066);
    repeat (3) adim(1);
    kontrol("kilit_mesgul", 32'(mesgul), 32'h1);
    rst_g = 1'b0;
    repeat (2) adim(1);
    rst_g = 1'b1;
    n0 = gozlem_q.size();
    repeat (3) adim(1);
    kontrol("rstk_aktarim", 32'(gozlem_q.size() - n0), 32'h0);
    kontrol("rstk_gecerli", 32'(komut_gecerli), 32'h0);
    kuyruk[1].push_back(9'h111);
    kuyruk[2].push_back(9'h122);
    kuyruk[3].push_back(9'h133);
    repeat (8) adim(1);
    kontrol("rstk_0", gozlem_al(n0),     32'h1100_0001);
    kontrol("rstk_1", gozlem_al(n0 + 1), 32'h2200_0001);
    kontrol("rstk_2", gozlem_al(n0 + 2), 32'h3300_0001);
    bosalt();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      komut_hazir = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0 && kuyruk[i].size() < 4)
          kuyruk[i].push_back({1'($urandom_range(0, 1)), 8'($urandom)});
      adim(1);
    end
    komut_hazir = 1'b1;
    bosalt();

    $display("test done: total=%0d bad=%0d", toplam, bad);
    $finish;
  end

endmodule
